dfr_output_layer: RTL and testbench
===================================

Name: dfr_output_layer

Overview:
- Readout stage directly downstream of the reservoir inside dfr_core_hybrid_top.
- Once the reservoir has filled the reservoir output memory, this block computes, per sample, the dot product of VIRTUAL_NODES reservoir states with the weight memory.
- Each result is written to the DFR output memory at address = sample index.
- Launched by the top-level control FSM after the reservoir run; drives part of the top-level busy.

Parameters:
- VIRTUAL_NODES, 10, reservoir nodes per sample (dot-product length), >=1.
- RESERVOIR_DATA_WIDTH, 32, width of reservoir states, weights and outputs (signed two's complement).
- RESERVOIR_HISTORY_ADDR_WIDTH, 16, address width of the reservoir output memory.
- WEIGHT_ADDR_WIDTH, 16, address width of the weight memory.
- OUTPUT_ADDR_WIDTH, 16, address width of the DFR output memory.
- FRAC_BITS, 0, fixed-point fraction bits; each final sum is arithmetically shifted right by FRAC_BITS.

Ports:
- S_AXI_ACLK  in  1  single clock.
- S_AXI_ARESETN  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle launch pulse.
- num_samples  in  32  samples to process; sampled when start is accepted.
- busy  out  1  high while processing.
- done  out  1  one-cycle completion pulse.
- res_mem_addr  out  RESERVOIR_HISTORY_ADDR_WIDTH  reservoir output memory read address.
- res_mem_rdata  in  RESERVOIR_DATA_WIDTH  read data, valid 1 cycle after address.
- weight_mem_addr  out  WEIGHT_ADDR_WIDTH  weight memory read address.
- weight_mem_rdata  in  RESERVOIR_DATA_WIDTH  read data, valid 1 cycle after address.
- out_mem_addr  out  OUTPUT_ADDR_WIDTH  DFR output memory write address.
- out_mem_wdata  out  RESERVOIR_DATA_WIDTH  write data.
- out_mem_wen  out  1  write enable, one cycle per sample.

Behaviour:
- Reset (S_AXI_ARESETN low, asynchronous): all outputs 0, state IDLE, counters and accumulator cleared.
- Reset mid-operation aborts immediately; no further writes occur.
- FSM states: IDLE, ISSUE, DRAIN, WRITE, FINISH.
- IDLE: start=1 latches num_samples.
  - num_samples=0: go to FINISH; busy stays 0.
  - Otherwise: go to ISSUE, busy=1, sample index s=0, node n=0.
- ISSUE: one read per cycle.
  - res_mem_addr = s*VIRTUAL_NODES + n; weight_mem_addr = n.
  - n increments each cycle; after n=VIRTUAL_NODES-1, go to DRAIN.
- Datapath pipeline:
  - Read data arrives 1 cycle after address.
  - Signed product registered 1 cycle later.
  - Product added to the accumulator the following cycle.
  - Valid flags track each pipeline stage.
- DRAIN: 2 cycles to flush the pipeline, then WRITE.
- WRITE:
  - out_mem_wen=1, out_mem_addr=s.
  - out_mem_wdata = saturate(acc >>> FRAC_BITS) to RESERVOIR_DATA_WIDTH signed range: max 0x7FFFFFFF, min 0x80000000 at default width.
  - Accumulator clears.
  - If s = num_samples-1, go to FINISH; else s++, n=0, back to ISSUE.
- Per-sample time: VIRTUAL_NODES + 3 cycles (ISSUE + 2 DRAIN + WRITE).
- FINISH: done=1 for one cycle, busy=0 in that same cycle, then IDLE.
- Total time: start accepted at cycle 0 → done at cycle num_samples*(VIRTUAL_NODES+3)+1.
- Accumulator width: 2*RESERVOIR_DATA_WIDTH + clog2(VIRTUAL_NODES); it never overflows internally.
- start while busy (or in FINISH) is ignored; num_samples is not re-latched.
- Address wrap: res_mem_addr is truncated to RESERVOIR_HISTORY_ADDR_WIDTH; software keeps num_samples*VIRTUAL_NODES within memory depth.
- Memory outputs are undriven-by-contract when not reading: addresses hold their last value, and out_mem_wen is 0 outside WRITE.

Decomposition:
- Shared package dfr_pkg:
  - State enum type.
  - acc_width(data_w, nodes) function.
  - Signed saturate(acc, frac_bits, out_w) function.
- Sub-module dfr_mac_pipe:
  - Valid-tagged read, multiply and accumulate pipeline.
  - Inputs: clear, in_valid, a, b. Output: acc.
  - Keeps FSM and arithmetic separable.

Test Plan:
- Basic dot product: VIRTUAL_NODES=10, reservoir mem[k]=k for k=0..49, all weights=1, num_samples=5, start → writes 45,145,245,345,445 to addresses 0..4; done at cycle 66; busy high cycles 1..65.
- Signed and saturation: sample 0 all 0x7FFFFFFF with weights 2 → 0x7FFFFFFF; sample 1 all 0x80000000 with weights 2 → 0x80000000; mixed sample of +3 with weights -1 → 0xFFFFFFE2 (-30).
- Fixed point: FRAC_BITS=16, reservoir all 0x00010000, weights 0x00008000, 1 sample → 0x00050000.
- Zero samples: num_samples=0, start → done pulses next cycle; busy and out_mem_wen never assert.
- Start while busy: second start pulse at cycle 10 with num_samples=99 → ignored; exactly 5 writes; done at cycle 66.
- Reset mid-run: assert S_AXI_ARESETN=0 during sample 2 → all outputs 0 immediately; no writes after reset; a fresh start after release reproduces the basic results.

Source files
------------

// File: rtl/dfr_pkg.sv
// Shared types and arithmetic helpers for the DFR readout layer.
// The saturate helper works at a fixed wide width so any accumulator size fits.
package dfr_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      DRAIN,
      WRITE,
      FINISH
   } state_e;

   localparam int SAT_W = 128;

   function automatic int acc_width(input int data_w, input int nodes);
      return 2 * data_w + $clog2(nodes);
   endfunction

   // Arithmetic shift right by frac_bits, then clamp to the signed out_w range.
   function automatic logic signed [SAT_W-1:0] saturate(
      input logic signed [SAT_W-1:0] acc,
      input int                      frac_bits,
      input int                      out_w
   );
      logic signed [SAT_W-1:0] shifted;
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      shifted = acc >>> frac_bits;
      hi      = (SAT_W'(1) <<< (out_w - 1)) - SAT_W'(1);
      lo      = -hi - SAT_W'(1);
      if (shifted > hi) return hi;
      if (shifted < lo) return lo;
      return shifted;
   endfunction

endpackage

// File: rtl/dfr_mac_pipe.sv
// Valid-tagged read / multiply / accumulate pipeline for the DFR readout.
// Operands arrive one cycle after in_valid_i; the product lands in acc_o two cycles later.
module dfr_mac_pipe
   import dfr_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int NODES  = 10,
   parameter int ACC_W  = acc_width(DATA_W, NODES)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear_i,
   input  logic              in_valid_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   output logic [ACC_W-1:0]  acc_o
);

   localparam int PROD_W = 2 * DATA_W;

   logic signed [DATA_W-1:0] a_s;
   logic signed [DATA_W-1:0] b_s;
   logic                     rd_v_q;
   logic                     mul_v_q;
   logic signed [PROD_W-1:0] prod_q;
   logic signed [ACC_W-1:0]  acc_q;

   assign a_s   = a_i;
   assign b_s   = b_i;
   assign acc_o = acc_q;

   // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_v_q  <= 1'b0;
         mul_v_q <= 1'b0;
         prod_q  <= '0;
         acc_q   <= '0;
      end else begin
         rd_v_q  <= in_valid_i;
         mul_v_q <= rd_v_q;
         if (rd_v_q) prod_q <= PROD_W'(a_s) * PROD_W'(b_s);
         if (clear_i)      acc_q <= '0;
         else if (mul_v_q) acc_q <= acc_q + ACC_W'(prod_q);
      end
   end

endmodule

// File: rtl/dfr_output_layer.sv
// DFR readout: per sample, dot product of VIRTUAL_NODES reservoir states with the weights,
// saturated and written to the output memory at address = sample index.
module dfr_output_layer
   import dfr_pkg::*;
#(
   parameter int VIRTUAL_NODES                = 10,
   parameter int RESERVOIR_DATA_WIDTH         = 32,
   parameter int RESERVOIR_HISTORY_ADDR_WIDTH = 16,
   parameter int WEIGHT_ADDR_WIDTH            = 16,
   parameter int OUTPUT_ADDR_WIDTH            = 16,
   parameter int FRAC_BITS                    = 0
) (
   input  logic                                    S_AXI_ACLK,
   input  logic                                    S_AXI_ARESETN,
   input  logic                                    start,
   input  logic [31:0]                             num_samples,
   output logic                                    busy,
   output logic                                    done,
   output logic [RESERVOIR_HISTORY_ADDR_WIDTH-1:0] res_mem_addr,
   input  logic [RESERVOIR_DATA_WIDTH-1:0]         res_mem_rdata,
   output logic [WEIGHT_ADDR_WIDTH-1:0]            weight_mem_addr,
   input  logic [RESERVOIR_DATA_WIDTH-1:0]         weight_mem_rdata,
   output logic [OUTPUT_ADDR_WIDTH-1:0]            out_mem_addr,
   output logic [RESERVOIR_DATA_WIDTH-1:0]         out_mem_wdata,
   output logic                                    out_mem_wen
);

   localparam int RHAW  = RESERVOIR_HISTORY_ADDR_WIDTH;
   localparam int ACC_W = acc_width(RESERVOIR_DATA_WIDTH, VIRTUAL_NODES);
   localparam int NW    = (VIRTUAL_NODES > 1) ? $clog2(VIRTUAL_NODES) : 1;
   localparam logic [NW-1:0]   N_LAST     = NW'(VIRTUAL_NODES - 1);
   localparam logic [RHAW-1:0] RES_STRIDE = RHAW'(VIRTUAL_NODES);

   state_e           state_q, state_d;
   logic [31:0]      num_q, num_d;
   logic [31:0]      s_q, s_d;
   logic [NW-1:0]    n_q, n_d;
   logic [RHAW-1:0]  base_q, base_d;
   logic             drain_q, drain_d;
   logic [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] acc_s;

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         state_q <= IDLE;
         num_q   <= '0;
         s_q     <= '0;
         n_q     <= '0;
         base_q  <= '0;
         drain_q <= 1'b0;
      end else begin
         state_q <= state_d;
         num_q   <= num_d;
         s_q     <= s_d;
         n_q     <= n_d;
         base_q  <= base_d;
         drain_q <= drain_d;
      end
   end

   // NOTE: every always_comb target gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      num_d   = num_q;
      s_d     = s_q;
      n_d     = n_q;
      base_d  = base_q;
      drain_d = drain_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               num_d = num_samples;
               if (num_samples == 32'd0) begin
                  state_d = FINISH;
               end else begin
                  state_d = ISSUE;
                  s_d     = '0;
                  n_d     = '0;
                  base_d  = '0;
                  drain_d = 1'b0;
               end
            end
         end
         ISSUE: begin
            if (n_q == N_LAST) state_d = DRAIN;
            else               n_d     = n_q + NW'(1);
         end
         DRAIN: begin
            drain_d = ~drain_q;
            if (drain_q) state_d = WRITE;
         end
         WRITE: begin
            if (s_q == num_q - 32'd1) begin
               state_d = FINISH;
            end else begin
               state_d = ISSUE;
               s_d     = s_q + 32'd1;
               n_d     = '0;
               base_d  = base_q + RES_STRIDE;
            end
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Address registers only move on entry to an issue cycle, so they hold between reads.
   assign res_mem_addr    = base_q + RHAW'(n_q);
   assign weight_mem_addr = WEIGHT_ADDR_WIDTH'(n_q);
   assign out_mem_addr    = OUTPUT_ADDR_WIDTH'(s_q);
   assign busy            = (state_q == ISSUE) || (state_q == DRAIN) || (state_q == WRITE);
   assign done            = (state_q == FINISH);
   assign out_mem_wen     = (state_q == WRITE);

   assign acc_s         = acc;
   assign out_mem_wdata = out_mem_wen
      ? RESERVOIR_DATA_WIDTH'(saturate(SAT_W'(acc_s), FRAC_BITS, RESERVOIR_DATA_WIDTH))
      : '0;

   dfr_mac_pipe #(
      .DATA_W (RESERVOIR_DATA_WIDTH),
      .NODES  (VIRTUAL_NODES),
      .ACC_W  (ACC_W)
   ) u_mac (
      .clk        (S_AXI_ACLK),
      .rst_n      (S_AXI_ARESETN),
      .clear_i    ((state_q == WRITE) || (state_q == IDLE)),
      .in_valid_i (state_q == ISSUE),
      .a_i        (res_mem_rdata),
      .b_i        (weight_mem_rdata),
      .acc_o      (acc)
   );

endmodule

// File: tb/tb_dfr_output_layer.sv
// Self-checking bench for dfr_output_layer: vector tables, corner sequences and a
// randomized run compared against a plain-arithmetic dot-product model.
module tb_dfr_output_layer;

   localparam int V = 10;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] num_samples = '0;
   logic        busy, done, out_wen;
   logic [15:0] res_addr, w_addr, out_addr;
   logic [31:0] res_rdata, w_rdata, out_wdata;

   logic        start2 = 1'b0;
   logic [31:0] num2 = '0;
   logic        busy2, done2, out_wen2;
   logic [15:0] res_addr2, w_addr2, out_addr2;
   logic [31:0] res_rdata2, w_rdata2, out_wdata2;

   logic [31:0] res_mem  [0:1023];
   logic [31:0] w_mem    [0:15];
   logic [31:0] res_mem2 [0:15];
   logic [31:0] w_mem2   [0:15];

   int          wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   int          n_checks = 0;
   int          n_err = 0;

   typedef struct {
      int          addr;
      logic [31:0] data;
   } wr_vec_t;

   typedef struct {
      int num;
      int exp_done;
      int exp_busy;
   } job_vec_t;

   always #5 clk = ~clk;

   dfr_output_layer dut (
      .S_AXI_ACLK       (clk),
      .S_AXI_ARESETN    (rst_n),
      .start            (start),
      .num_samples      (num_samples),
      .busy             (busy),
      .done             (done),
      .res_mem_addr     (res_addr),
      .res_mem_rdata    (res_rdata),
      .weight_mem_addr  (w_addr),
      .weight_mem_rdata (w_rdata),
      .out_mem_addr     (out_addr),
      .out_mem_wdata    (out_wdata),
      .out_mem_wen      (out_wen)
   );

   dfr_output_layer #(.FRAC_BITS(16)) dut_fx (
      .S_AXI_ACLK       (clk),
      .S_AXI_ARESETN    (rst_n),
      .start            (start2),
      .num_samples      (num2),
      .busy             (busy2),
      .done             (done2),
      .res_mem_addr     (res_addr2),
      .res_mem_rdata    (res_rdata2),
      .weight_mem_addr  (w_addr2),
      .weight_mem_rdata (w_rdata2),
      .out_mem_addr     (out_addr2),
      .out_mem_wdata    (out_wdata2),
      .out_mem_wen      (out_wen2)
   );

   // Synchronous-read memories: data valid one cycle after the address.
   always @(posedge clk) begin
      res_rdata  <= res_mem[res_addr[9:0]];
      w_rdata    <= w_mem[w_addr[3:0]];
      res_rdata2 <= res_mem2[res_addr2[3:0]];
      w_rdata2   <= w_mem2[w_addr2[3:0]];
   end

   always @(negedge clk) begin
      if (out_wen) begin
         wr_addr_q.push_back(int'(out_addr));
         wr_data_q.push_back(out_wdata);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Exact dot product, then clamp to the signed 32-bit range.
   function automatic logic [31:0] model(input int s);
      logic signed [127:0] sum, a, b;
      logic [31:0]         r, w;
      sum = '0;
      for (int n = 0; n < V; n++) begin
         r   = res_mem[s * V + n];
         w   = w_mem[n];
         a   = {{96{r[31]}}, r};
         b   = {{96{w[31]}}, w};
         sum = sum + a * b;
      end
      if (sum > 128'sh7FFF_FFFF)        return 32'h7FFF_FFFF;
      if (sum < -128'sh8000_0000)       return 32'h8000_0000;
      return sum[31:0];
   endfunction

   task automatic load_basic();
      for (int k = 0; k < 1024; k++) res_mem[k] = k;
      for (int k = 0; k < 16; k++)   w_mem[k] = 32'd1;
   endtask

   // Pulses start, then watches cycles 1..budget after the accepting edge.
   task automatic run_job(input int num, input int inj_cyc, input int budget,
                          output int done_cyc, output int busy_first,
                          output int busy_last, output int busy_cnt);
      @(negedge clk);
      wr_addr_q.delete();
      wr_data_q.delete();
      start       = 1'b1;
      num_samples = num;
      @(posedge clk);
      done_cyc = -1; busy_first = -1; busy_last = -1; busy_cnt = 0;
      for (int k = 1; k <= budget; k++) begin
         @(negedge clk);
         start = (k == inj_cyc);
         if (k == inj_cyc) num_samples = 32'd99;
         if (busy) begin
            busy_cnt++;
            if (busy_first < 0) busy_first = k;
            busy_last = k;
         end
         if (done) begin
            done_cyc = k;
            break;
         end
         @(posedge clk);
      end
      start = 1'b0;
   endtask

   task automatic check_writes(input string tag, input wr_vec_t tbl[5]);
      check({tag, "_count"}, 64'(wr_data_q.size()), 64'd5);
      for (int i = 0; i < 5; i++) begin
         check({tag, "_addr"}, (i < wr_addr_q.size()) ? 64'(wr_addr_q[i]) : 64'hDEAD, 64'(tbl[i].addr));
         check({tag, "_data"}, (i < wr_data_q.size()) ? 64'(wr_data_q[i]) : 64'hDEAD, 64'(tbl[i].data));
      end
   endtask

   initial begin
      wr_vec_t  basic_tbl[5];
      job_vec_t job_tbl[3];
      int       dc, bf, bl, bc, num, seen;
      logic [31:0] fx_data;

      basic_tbl = '{'{0, 32'd45}, '{1, 32'd145}, '{2, 32'd245}, '{3, 32'd345}, '{4, 32'd445}};
      job_tbl   = '{'{1, 14, 13}, '{2, 27, 26}, '{0, 1, 0}};

      load_basic();
      for (int k = 0; k < 16; k++) begin
         res_mem2[k] = 32'h0001_0000;
         w_mem2[k]   = 32'h0000_8000;
      end

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy_done_wen", {61'd0, busy, done, out_wen}, 64'd0);
      check("rst_addrs", {16'd0, res_addr, w_addr, out_addr}, 64'd0);
      check("rst_wdata", 64'(out_wdata), 64'd0);
      rst_n = 1'b1;

      // Basic dot product
      run_job(5, 0, 200, dc, bf, bl, bc);
      check("basic_done_cyc", 64'(dc), 64'd66);
      check("basic_busy_first", 64'(bf), 64'd1);
      check("basic_busy_last", 64'(bl), 64'd65);
      check("basic_busy_cnt", 64'(bc), 64'd65);
      check_writes("basic", basic_tbl);

      // Job timing table, including zero samples
      foreach (job_tbl[j]) begin
         run_job(job_tbl[j].num, 0, 200, dc, bf, bl, bc);
         check("job_done_cyc", 64'(dc), 64'(job_tbl[j].exp_done));
         check("job_busy_cnt", 64'(bc), 64'(job_tbl[j].exp_busy));
         check("job_writes", 64'(wr_data_q.size()), 64'(job_tbl[j].num));
      end

      // Start while busy is ignored
      run_job(5, 10, 300, dc, bf, bl, bc);
      check("busy_start_done_cyc", 64'(dc), 64'd66);
      check_writes("busy_start", basic_tbl);

      // Saturation high/low with weights 2, then signed -1 weights
      for (int k = 0; k < 10; k++) begin
         res_mem[k]      = 32'h7FFF_FFFF;
         res_mem[10 + k] = 32'h8000_0000;
         w_mem[k]        = 32'd2;
      end
      run_job(2, 0, 100, dc, bf, bl, bc);
      check("sat_count", 64'(wr_data_q.size()), 64'd2);
      check("sat_hi", (wr_data_q.size() > 0) ? 64'(wr_data_q[0]) : 64'hDEAD, 64'h7FFF_FFFF);
      check("sat_lo", (wr_data_q.size() > 1) ? 64'(wr_data_q[1]) : 64'hDEAD, 64'h8000_0000);
      for (int k = 0; k < 10; k++) begin
         res_mem[k] = 32'd3;
         w_mem[k]   = 32'hFFFF_FFFF;
      end
      run_job(1, 0, 100, dc, bf, bl, bc);
      check("signed_neg30", (wr_data_q.size() > 0) ? 64'(wr_data_q[0]) : 64'hDEAD, 64'hFFFF_FFE2);

      // Reset in the middle of sample 2
      load_basic();
      @(negedge clk);
      wr_addr_q.delete();
      wr_data_q.delete();
      start = 1'b1;
      num_samples = 32'd5;
      @(posedge clk);
      repeat (30) @(negedge clk);
      start = 1'b0;
      rst_n = 1'b0;
      #1;
      check("midrst_ctrl", {61'd0, busy, done, out_wen}, 64'd0);
      check("midrst_addrs", {16'd0, res_addr, w_addr, out_addr}, 64'd0);
      check("midrst_writes_before", 64'(wr_data_q.size()), 64'd2);
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      check("midrst_no_writes_after", 64'(wr_data_q.size()), 64'd2);
      run_job(5, 0, 200, dc, bf, bl, bc);
      check("midrst_rerun_done_cyc", 64'(dc), 64'd66);
      check_writes("midrst_rerun", basic_tbl);

      // Randomized samples against the model
      for (int it = 0; it < 4; it++) begin
         for (int k = 0; k < 80; k++)
            res_mem[k] = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 2000)) - 32'd1000 : $urandom;
         for (int k = 0; k < V; k++)
            w_mem[k] = ($urandom_range(0, 3) != 0) ? 32'($urandom_range(0, 2000)) - 32'd1000 : $urandom;
         num = $urandom_range(1, 8);
         run_job(num, 0, 300, dc, bf, bl, bc);
         check("rand_done_cyc", 64'(dc), 64'(num * (V + 3) + 1));
         check("rand_count", 64'(wr_data_q.size()), 64'(num));
         for (int i = 0; i < num; i++) begin
            check("rand_addr", (i < wr_addr_q.size()) ? 64'(wr_addr_q[i]) : 64'hDEAD, 64'(i));
            check("rand_data", (i < wr_data_q.size()) ? 64'(wr_data_q[i]) : 64'hDEAD, 64'(model(i)));
         end
      end

      // Fixed-point instance, FRAC_BITS=16
      @(negedge clk);
      start2 = 1'b1;
      num2   = 32'd1;
      @(posedge clk);
      seen = 0;
      fx_data = '0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         start2 = 1'b0;
         if (out_wen2 && seen == 0) begin
            seen    = 1;
            fx_data = out_wdata2;
            check("fx_addr", 64'(out_addr2), 64'd0);
         end
         if (done2) break;
      end
      check("fx_write_seen", 64'(seen), 64'd1);
      check("fx_data", 64'(fx_data), 64'h0005_0000);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
